// File: rtl/fft16_stage2_ctrl.sv
// Frame controller around a combinational 16-point stage-2 datapath.
// Collects 16 samples, captures all datapath results in one cycle, then streams them out.
module fft16_stage2_ctrl #(
    parameter int INW  = 16,
    parameter int OUTW = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INW-1:0]       in_re,
    input  logic [INW-1:0]       in_im,
    output logic [16*INW-1:0]    dp_xr_flat,
    output logic [16*INW-1:0]    dp_xi_flat,
    input  logic [16*OUTW-1:0]   dp_yr_flat,
    input  logic [16*OUTW-1:0]   dp_yi_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUTW-1:0]      out_re,
    output logic [OUTW-1:0]      out_im,
    output logic [3:0]           out_idx,
    output logic                 out_last,
    output logic                 busy
);

    // state   | meaning
    // LOAD    | accepting samples 0..15 into the input buffer
    // COMPUTE | one cycle; datapath results latched into the result bank
    // UNLOAD  | streaming results 0..15 with valid/ready handshake
    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        UNLOAD  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]      wr_cnt;
    logic [3:0]      rd_cnt;
    logic [INW-1:0]  xr_buf  [16];
    logic [INW-1:0]  xi_buf  [16];
    logic [OUTW-1:0] yr_bank [16];
    logic [OUTW-1:0] yi_bank [16];

    logic load_fire;
    logic unload_fire;
    logic capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        load_fire   = 1'b0;
        unload_fire = 1'b0;
        capture     = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_fire = 1'b1;
                    if (wr_cnt == 4'd15) begin
                        state_nxt = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                capture   = 1'b1;
                state_nxt = UNLOAD;
            end
            UNLOAD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    unload_fire = 1'b1;
                    if (rd_cnt == 4'd15) begin
                        state_nxt = LOAD;
                    end
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= 4'd0;
            rd_cnt <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                xr_buf[i]  <= '0;
                xi_buf[i]  <= '0;
                yr_bank[i] <= '0;
                yi_bank[i] <= '0;
            end
        end else begin
            if (load_fire) begin
                xr_buf[wr_cnt] <= in_re;
                xi_buf[wr_cnt] <= in_im;
                wr_cnt         <= wr_cnt + 4'd1;
            end
            if (capture) begin
                for (int k = 0; k < 16; k++) begin
                    yr_bank[k] <= dp_yr_flat[k*OUTW +: OUTW];
                    yi_bank[k] <= dp_yi_flat[k*OUTW +: OUTW];
                end
            end
            if (unload_fire) begin
                rd_cnt <= rd_cnt + 4'd1;
            end
        end
    end

    // The buffer only changes in LOAD, so the datapath inputs are stable through COMPUTE.
    for (genvar n = 0; n < 16; n++) begin : g_flat
        assign dp_xr_flat[n*INW +: INW] = xr_buf[n];
        assign dp_xi_flat[n*INW +: INW] = xi_buf[n];
    end

    assign out_re   = yr_bank[rd_cnt];
    assign out_im   = yi_bank[rd_cnt];
    assign out_idx  = rd_cnt;
    assign out_last = out_valid && (rd_cnt == 4'd15);
    assign busy     = !((state == LOAD) && (wr_cnt == 4'd0));

endmodule

// File: tb/tb_fft16_stage2_ctrl.sv
// Bench for fft16_stage2_ctrl: behavioural stage-2 datapath (four 4-point DFTs, Q15 unity gain)
// on the dp_* ports, queue scoreboard filled at frame accept and drained on output transfers.
module tb_fft16_stage2_ctrl;

    localparam int INW  = 16;
    localparam int OUTW = 48;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [INW-1:0]      in_re;
    logic [INW-1:0]      in_im;
    logic [16*INW-1:0]   dp_xr_flat;
    logic [16*INW-1:0]   dp_xi_flat;
    logic [16*OUTW-1:0]  dp_yr_flat;
    logic [16*OUTW-1:0]  dp_yi_flat;
    logic                out_valid;
    logic                out_ready;
    logic [OUTW-1:0]     out_re;
    logic [OUTW-1:0]     out_im;
    logic [3:0]          out_idx;
    logic                out_last;
    logic                busy;

    fft16_stage2_ctrl #(.INW(INW), .OUTW(OUTW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .dp_xr_flat (dp_xr_flat),
        .dp_xi_flat (dp_xi_flat),
        .dp_yr_flat (dp_yr_flat),
        .dp_yi_flat (dp_yi_flat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Output k = g + 4p from group g inputs x[g+4m], twiddle (-j)^(m*p), scaled by 32767.
    function automatic longint stage_out(input longint ar[16], input longint ai[16],
                                         input int k, input bit want_im);
        longint acc_re = 0;
        longint acc_im = 0;
        int g = k % 4;
        int p = k / 4;
        for (int m = 0; m < 4; m++) begin
            longint a = ar[g + 4*m];
            longint b = ai[g + 4*m];
            case ((m * p) % 4)
                0: begin acc_re += a; acc_im += b; end
                1: begin acc_re += b; acc_im -= a; end
                2: begin acc_re -= a; acc_im -= b; end
                default: begin acc_re -= b; acc_im += a; end
            endcase
        end
        return (want_im ? acc_im : acc_re) * 64'sd32767;
    endfunction

    longint dxr [16];
    longint dxi [16];

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            dxr[k] = longint'($signed(dp_xr_flat[k*INW +: INW]));
            dxi[k] = longint'($signed(dp_xi_flat[k*INW +: INW]));
        end
    end

    always_comb begin
        dp_yr_flat = '0;
        dp_yi_flat = '0;
        for (int k = 0; k < 16; k++) begin
            dp_yr_flat[k*OUTW +: OUTW] = OUTW'(stage_out(dxr, dxi, k, 1'b0));
            dp_yi_flat[k*OUTW +: OUTW] = OUTW'(stage_out(dxr, dxi, k, 1'b1));
        end
    end

    typedef struct {
        longint re;
        longint im;
        int     idx;
    } exp_t;

    exp_t   sb [$];
    longint st_re [$];
    longint st_im [$];
    longint obs_re [16];
    longint obs_im [16];
    int     accept_edge = 0;

    task automatic produce(input int gap_pct);
        longint fr_re [16];
        longint fr_im [16];
        int idx = 0;
        int budget = 0;
        while (st_re.size() > 0 && budget < 4000) begin
            @(negedge clk);
            budget++;
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_re    = INW'(st_re[0]);
                in_im    = INW'(st_im[0]);
            end
            if (in_valid && in_ready) begin
                fr_re[idx] = st_re.pop_front();
                fr_im[idx] = st_im.pop_front();
                idx++;
                if (idx == 16) begin
                    for (int k = 0; k < 16; k++) begin
                        exp_t e;
                        e.re  = stage_out(fr_re, fr_im, k, 1'b0);
                        e.im  = stage_out(fr_re, fr_im, k, 1'b1);
                        e.idx = k;
                        sb.push_back(e);
                    end
                    accept_edge = cyc + 1;
                    idx = 0;
                end
            end
        end
        if (budget >= 4000) check_eq("producer_timeout", budget, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic consume(input int total, input int stall_pct);
        int  got = 0;
        int  budget = 0;
        bit  prev_valid = 1'b0;
        while (got < total && budget < 6000) begin
            @(negedge clk);
            budget++;
            out_ready = ($urandom_range(99) >= stall_pct);
            if (out_valid) begin
                check_eq("in_ready_unload", in_ready, 0);
                check_eq("sb_nonempty", sb.size() > 0, 1);
                if (!prev_valid) check_eq("latency", cyc + 1 - accept_edge, 2);
                if (sb.size() > 0) begin
                    check_eq("out_re",   longint'($signed(out_re)), sb[0].re);
                    check_eq("out_im",   longint'($signed(out_im)), sb[0].im);
                    check_eq("out_idx",  out_idx, sb[0].idx);
                    check_eq("out_last", out_last, sb[0].idx == 15);
                    if (out_ready) begin
                        obs_re[sb[0].idx] = longint'($signed(out_re));
                        obs_im[sb[0].idx] = longint'($signed(out_im));
                        void'(sb.pop_front());
                        got++;
                    end
                end
            end
            prev_valid = out_valid;
        end
        if (budget >= 6000) check_eq("consumer_timeout", got, total);
    endtask

    task automatic run_frames(input int nf, input int gap_pct, input int stall_pct);
        fork
            produce(gap_pct);
            consume(nf * 16, stall_pct);
        join
    endtask

    task automatic push_random_frame();
        for (int n = 0; n < 16; n++) begin
            st_re.push_back(longint'($urandom_range(65535)) - 32768);
            st_im.push_back(longint'($urandom_range(65535)) - 32768);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_in_ready"},  in_ready, 1);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_out_last"},  out_last, 0);
        check_eq({tag, "_out_idx"},   out_idx, 0);
        check_eq({tag, "_out_re"},    longint'($signed(out_re)), 0);
        check_eq({tag, "_out_im"},    longint'($signed(out_im)), 0);
        check_eq({tag, "_busy"},      busy, 0);
    endtask

    initial begin
        in_re = '0;
        in_im = '0;
        do_reset();
        check_idle("reset");

        // One sample into LOAD, then reset discards it.
        in_valid = 1'b1;
        in_re    = INW'(16'sd77);
        in_im    = '0;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("busy_partial", busy, 1);
        check_eq("in_ready_partial", in_ready, 1);
        do_reset();
        check_idle("reset_load");

        // Impulse
        for (int n = 0; n < 16; n++) begin
            st_re.push_back(n == 0 ? 64'sd1000 : 64'sd0);
            st_im.push_back(0);
        end
        run_frames(1, 0, 0);
        for (int k = 0; k < 16; k++) begin
            check_eq("impulse_re", obs_re[k], (k % 4 == 0) ? 64'sd32767000 : 64'sd0);
            check_eq("impulse_im", obs_im[k], 0);
        end

        // DC
        for (int n = 0; n < 16; n++) begin
            st_re.push_back(1);
            st_im.push_back(0);
        end
        run_frames(1, 0, 0);
        check_eq("dc_re0", obs_re[0], 131068);
        check_eq("dc_im0", obs_im[0], 0);

        // Backpressure
        push_random_frame();
        run_frames(1, 0, 50);

        // Back-to-back frames, in_valid held high
        push_random_frame();
        push_random_frame();
        run_frames(2, 0, 0);

        // Input gaps plus light stalls
        push_random_frame();
        run_frames(1, 40, 20);

        // Reset during UNLOAD at index 7, coinciding with a handshake
        push_random_frame();
        produce(0);
        consume(7, 0);
        @(negedge clk);
        check_eq("pre_reset_idx", out_idx, 7);
        check_eq("pre_reset_valid", out_valid, 1);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset_unload");
        sb.delete();

        push_random_frame();
        run_frames(1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fft16_stage2_ctrl.md
FFT16_STAGE2_CTRL -- requirements
Module: fft16_stage2_ctrl

Interface
REQ-001 Parameter: INW, 16, sample width per real/imag component on input side.
REQ-002 Parameter: OUTW, 48, width per real/imag component of datapath results.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: in_valid  input  1  input sample present.
REQ-006 Port: in_ready  output  1  controller accepts input sample this cycle.
REQ-007 Port: in_re, in_im  input  INW each  signed input sample, natural index order 0..15.
REQ-008 Port: dp_xr_flat, dp_xi_flat  output  16*INW each  frame buffer to stage-2 datapath; sample n occupies bits [n*INW +: INW].
REQ-009 Port: dp_yr_flat, dp_yi_flat  input  16*OUTW each  combinational results from stage-2 datapath; result k occupies bits [k*OUTW +: OUTW].
REQ-010 Port: out_valid  output  1  output sample present.
REQ-011 Port: out_ready  input  1  downstream accepts output sample.
REQ-012 Port: out_re, out_im  output  OUTW each  signed result sample.
REQ-013 Port: out_idx  output  4  index k of current output sample.
REQ-014 Port: out_last  output  1  high with out_valid when out_idx = 15.
REQ-015 Port: busy  output  1  high in any state other than LOAD with zero samples held.

Function
REQ-016 FSM states SHALL be LOAD, COMPUTE, UNLOAD.
REQ-017 LOAD: in_ready = 1; on in_valid & in_ready, write sample to buffer slot wr_cnt, increment 4-bit wr_cnt.
REQ-018 LOAD -> COMPUTE on the accept with wr_cnt = 15; wr_cnt wraps to 0.
REQ-019 COMPUTE lasts exactly 1 cycle: in_ready = 0, out_valid = 0; at cycle end, all 16 dp_yr/dp_yi results captured into a 16-entry output register bank; -> UNLOAD.
REQ-020 dp_xr_flat/dp_xi_flat SHALL be driven directly from the input buffer, stable throughout COMPUTE.
REQ-021 UNLOAD: out_valid = 1; out_re/out_im = captured result rd_cnt; out_idx = rd_cnt.
REQ-022 Output handshake: rd_cnt advances only on out_valid & out_ready; out_* held stable while out_ready = 0.
REQ-023 UNLOAD -> LOAD on the transfer with rd_cnt = 15; rd_cnt wraps to 0.
REQ-024 in_ready SHALL be 0 in COMPUTE and UNLOAD; input buffer not overwritten before the frame's results are captured.
REQ-025 Latency: first out_valid on the 2nd rising edge after the edge accepting sample 15 (one COMPUTE cycle).
REQ-026 Captured results stored at full OUTW width; no truncation, rounding or saturation.
REQ-027 Throughput: one frame per 16 + 1 + 16 cycles minimum with continuous in_valid/out_ready.
REQ-028 in_valid while in_ready = 0 is ignored; no sample lost or duplicated.

Reset
REQ-029 rst high at a rising edge: state = LOAD, wr_cnt = 0, rd_cnt = 0, out_valid = 0, out_last = 0, out_idx = 0, out_re = out_im = 0, in_ready = 1 after reset, busy = 0.
REQ-030 Input buffer and result bank cleared to 0 on reset.
REQ-031 Reset mid-LOAD, mid-COMPUTE or mid-UNLOAD discards the partial frame; next accepted sample is index 0.
REQ-032 rst has priority over any simultaneous handshake in the same cycle.

Verification (bench instantiates the stage-2 datapath on dp_* ports)
REQ-033 Impulse: x[0] = 1000+0j, others 0, out_ready = 1 -> out_re = 32767000 at idx 0,4,8,12, 0 at others; all out_im = 0; out_last only at idx 15.
REQ-034 DC: all x = 1+0j -> idx 0: out_re = 131068, out_im = 0; first out_valid exactly 2 cycles after accept of sample 15.
REQ-035 Backpressure: out_ready toggled pseudo-randomly -> 16 outputs in order 0..15, values unchanged while stalled, in_ready = 0 until idx 15 transfers.
REQ-036 Back-to-back frames: two frames streamed, in_valid held 1 -> second frame accepted only after first frame's idx 15 transfer; both result sets correct.
REQ-037 Reset mid-UNLOAD at idx 7 -> next cycle out_valid = 0, in_ready = 1; new frame processed correctly from index 0.
REQ-038 Input gaps: in_valid deasserted for random cycles during LOAD -> wr_cnt holds; results identical to gap-free run.
